// File: rtl/instruction_fetch.sv
// Fetch stage: issues sequential word fetches on a valid/ready port, buffers in-order
// responses in a prefetch FIFO and discards stale responses after a branch redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        MemReqValid,
  output logic [31:0] MemReqAddr,
  input  logic        MemReqReady,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData,
  output logic [31:0] Opcode,
  output logic [31:0] OpcodePC,
  output logic        OpcodeValid,
  input  logic        OpcodeReady
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_valid_q, req_valid_d;
  logic          opcode_valid_q, opcode_valid_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] aq_wr_q, aq_wr_d;
  logic [AW-1:0] aq_rd_q, aq_rd_d;

  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   aq_pc_q     [FIFO_DEPTH];

  logic          accept_s;
  logic          resp_s;
  logic          push_s;
  logic          pop_s;
  logic [CW:0]   credit_used_s;
  logic          redirect_pc_unused_s;

  assign redirect_pc_unused_s = ^RedirectPC[1:0];

  // A response with nothing outstanding is a memory protocol error and is ignored.
  assign accept_s = req_valid_q & MemReqReady;
  assign resp_s   = MemRespValid & (inflight_q != CNT_ZERO);
  assign push_s   = resp_s & (state_q == ST_RUN) & (stale_q == CNT_ZERO) & ~Redirect;
  assign pop_s    = opcode_valid_q & OpcodeReady & ~Redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (Redirect) begin
      fetch_pc_d = {RedirectPC[31:2], 2'b00};
    end else if (accept_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    aq_wr_d    = accept_s ? (aq_wr_q + PTR_ONE) : aq_wr_q;
    aq_rd_d    = resp_s ? (aq_rd_q + PTR_ONE) : aq_rd_q;
    if (accept_s && !resp_s) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!accept_s && resp_s) begin
      inflight_d = inflight_q - CNT_ONE;
    end else begin
      inflight_d = inflight_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = CNT_ZERO;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Every request outstanding at a redirect (including one accepted that cycle) is stale.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      ST_RUN: begin
        if (Redirect) begin
          stale_d = inflight_d;
          state_d = (inflight_d != CNT_ZERO) ? ST_DRAIN : ST_RUN;
        end else begin
          stale_d = CNT_ZERO;
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (resp_s && (stale_q != CNT_ZERO)) begin
          stale_d = stale_q - CNT_ONE;
        end else begin
          stale_d = stale_q;
        end
        state_d = (stale_d == CNT_ZERO) ? ST_RUN : ST_DRAIN;
      end
      default: begin
        state_d = ST_RUN;
        stale_d = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    credit_used_s  = {1'b0, inflight_d} + {1'b0, count_d};
    req_valid_d    = (state_d == ST_RUN) && (credit_used_s < DEPTH_C);
    opcode_valid_d = (count_d != CNT_ZERO);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_RUN;
      fetch_pc_q     <= RESET_PC;
      req_valid_q    <= 1'b0;
      opcode_valid_q <= 1'b0;
      inflight_q     <= CNT_ZERO;
      stale_q        <= CNT_ZERO;
      count_q        <= CNT_ZERO;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      aq_wr_q        <= '0;
      aq_rd_q        <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      req_valid_q    <= req_valid_d;
      opcode_valid_q <= opcode_valid_d;
      inflight_q     <= inflight_d;
      stale_q        <= stale_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      aq_wr_q        <= aq_wr_d;
      aq_rd_q        <= aq_rd_d;
    end
  end

  // The address queue pairs each in-order response with the address that requested it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]   <= 32'h0000_0000;
        aq_pc_q[i]     <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= MemRespData;
        fifo_pc_q[wr_ptr_q]   <= aq_pc_q[aq_rd_q];
      end
      if (accept_s) begin
        aq_pc_q[aq_wr_q] <= fetch_pc_q;
      end
    end
  end

  assign MemReqValid = req_valid_q;
  assign MemReqAddr  = fetch_pc_q;
  assign OpcodeValid = opcode_valid_q;
  assign Opcode      = fifo_data_q[rd_ptr_q];
  assign OpcodePC    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a
// transaction-level model (outstanding requests per redirect epoch, expected fetch stream).
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        Clock;
  logic        Reset_n;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemReqValid;
  logic [31:0] MemReqAddr;
  logic        MemReqReady;
  logic        MemRespValid;
  logic [31:0] MemRespData;
  logic [31:0] Opcode;
  logic [31:0] OpcodePC;
  logic        OpcodeValid;
  logic        OpcodeReady;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData), .Opcode(Opcode),
    .OpcodePC(OpcodePC), .OpcodeValid(OpcodeValid), .OpcodeReady(OpcodeReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          t;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle_n = 0;
  int          epoch = 0;
  req_t        pend[$];
  logic [31:0] fifo_pc[$];
  logic [31:0] cons[$];
  logic [31:0] accs[$];
  logic [31:0] exp_addr;
  logic        exp_req_valid;
  bit          last_acc;
  bit          last_rsp;

  function automatic logic [31:0] mk_data(input logic [31:0] a, input int e);
    logic [7:0] eb;
    eb = e[7:0];
    return (a ^ 32'hC3A5_5A3C) ^ {eb, ~eb, 16'h0000};
  endfunction

  function automatic logic [31:0] b32(input logic b);
    return {31'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] q[$], input int idx,
                       input logic [31:0] exp);
    logic [31:0] obs;
    obs = (idx < q.size()) ? q[idx] : 32'hxxxx_xxxx;
    chk(tag, obs, exp);
  endtask

  task automatic sample_checks();
    chk("req_valid", b32(MemReqValid), b32(exp_req_valid));
    chk("req_addr", MemReqAddr, exp_addr);
    chk("op_valid", b32(OpcodeValid), b32(fifo_pc.size() > 0));
    if (OpcodeValid === 1'b1 && fifo_pc.size() > 0) begin
      chk("op_pc", OpcodePC, fifo_pc[0]);
      chk("op_data", Opcode, mk_data(fifo_pc[0], epoch));
    end
  endtask

  // One clock cycle: check outputs, drive random inputs, advance the model across the edge.
  task automatic cyc(input bit redir, input logic [31:0] rpc, input int p_rdy,
                     input int p_resp, input int p_opr);
    bit   vld, opv, rdy, rsp, opr, acc, pop;
    int   stale;
    req_t h;
    @(negedge Clock);
    sample_checks();
    vld = (MemReqValid === 1'b1);
    opv = (OpcodeValid === 1'b1);
    rdy = (int'($urandom_range(99)) < p_rdy);
    opr = (int'($urandom_range(99)) < p_opr);
    rsp = (pend.size() > 0) && (pend[0].t < cycle_n) && (int'($urandom_range(99)) < p_resp);
    Redirect     = redir;
    RedirectPC   = rpc;
    MemReqReady  = rdy;
    OpcodeReady  = opr;
    MemRespValid = rsp;
    MemRespData  = rsp ? mk_data(pend[0].addr, pend[0].epoch) : $urandom();
    acc = vld & rdy;
    pop = opv & opr & !redir;
    last_acc = acc;
    last_rsp = rsp;
    if (pop && fifo_pc.size() > 0) begin
      cons.push_back(OpcodePC);
      void'(fifo_pc.pop_front());
    end
    if (rsp) begin
      h = pend.pop_front();
      if (h.epoch == epoch && !redir) fifo_pc.push_back(h.addr);
    end
    if (acc) begin
      pend.push_back('{addr: exp_addr, epoch: epoch, t: cycle_n});
      accs.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      fifo_pc.delete();
      epoch++;
      exp_addr = {rpc[31:2], 2'b00};
    end
    stale = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
    exp_req_valid = (stale == 0) && ((pend.size() + fifo_pc.size()) < DEPTH);
    cycle_n++;
  endtask

  task automatic reset_dut();
    @(negedge Clock);
    sample_checks();
    #2;
    Reset_n      = 1'b0;
    Redirect     = 1'b0;
    RedirectPC   = 32'h0000_0000;
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;
    MemRespData  = 32'h0000_0000;
    OpcodeReady  = 1'b0;
    #1;
    chk("rst_req_valid", b32(MemReqValid), 32'd0);
    chk("rst_op_valid", b32(OpcodeValid), 32'd0);
    chk("rst_req_addr", MemReqAddr, RESET_PC);
    chk("rst_opcode", Opcode, 32'h0000_0000);
    chk("rst_opcode_pc", OpcodePC, 32'h0000_0000);
    pend.delete();
    fifo_pc.delete();
    epoch++;
    exp_addr      = RESET_PC;
    exp_req_valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  task automatic flush(input logic [31:0] pc);
    cyc(1'b1, pc, 0, 100, 0);
    repeat (8) cyc(1'b0, 32'd0, 0, 100, 0);
  endtask

  initial begin
    int p_rdy, p_resp, p_opr;
    logic [31:0] rpc;
    Reset_n      = 1'b0;
    Redirect     = 1'b0;
    RedirectPC   = 32'h0000_0000;
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;
    MemRespData  = 32'h0000_0000;
    OpcodeReady  = 1'b0;
    exp_addr      = RESET_PC;
    exp_req_valid = 1'b0;
    reset_dut();

    // 1: reset release with an always-ready single-cycle memory
    accs.delete(); cons.delete();
    repeat (10) cyc(1'b0, 32'd0, 100, 100, 100);
    chk_q("t1_req0", accs, 0, 32'h0000_0000);
    chk_q("t1_req1", accs, 1, 32'h0000_0004);
    chk_q("t1_req2", accs, 2, 32'h0000_0008);
    chk_q("t1_op0", cons, 0, 32'h0000_0000);
    chk_q("t1_op1", cons, 1, 32'h0000_0004);
    chk_q("t1_op2", cons, 2, 32'h0000_0008);

    // 2: decoder stalled, requests stop at the credit limit
    flush(32'h0000_0200);
    accs.delete();
    repeat (12) cyc(1'b0, 32'd0, 100, 100, 0);
    chk("t2_credit_cap", accs.size(), DEPTH);
    repeat (6) cyc(1'b0, 32'd0, 100, 100, 100);

    // 3: redirect to an unaligned target with two requests outstanding
    flush(32'h0000_0300);
    accs.delete();
    repeat (2) cyc(1'b0, 32'd0, 100, 0, 0);
    chk("t3_two_inflight", accs.size(), 2);
    cyc(1'b1, 32'h0000_0103, 0, 0, 0);
    accs.delete(); cons.delete();
    repeat (4) cyc(1'b0, 32'd0, 0, 100, 100);
    repeat (6) cyc(1'b0, 32'd0, 100, 100, 100);
    chk_q("t3_first_req", accs, 0, 32'h0000_0100);
    chk_q("t3_first_op", cons, 0, 32'h0000_0100);

    // 4: redirect coincides with a response and a request accept
    flush(32'h0000_0400);
    cons.delete();
    cyc(1'b0, 32'd0, 100, 0, 0);
    cyc(1'b1, 32'h0000_0500, 100, 100, 100);
    chk("t4_acc_and_rsp", b32(last_acc & last_rsp), 32'd1);
    repeat (10) cyc(1'b0, 32'd0, 100, 100, 100);
    chk_q("t4_first_op", cons, 0, 32'h0000_0500);

    // 5: address wrap at the top of memory
    flush(32'hFFFF_FFFC);
    accs.delete(); cons.delete();
    repeat (8) cyc(1'b0, 32'd0, 100, 100, 100);
    chk_q("t5_req0", accs, 0, 32'hFFFF_FFFC);
    chk_q("t5_req1", accs, 1, 32'h0000_0000);
    chk_q("t5_op0", cons, 0, 32'hFFFF_FFFC);
    chk_q("t5_op1", cons, 1, 32'h0000_0000);

    // 6: reset with a full prefetch FIFO
    repeat (10) cyc(1'b0, 32'd0, 100, 100, 0);
    chk("t6_full_before_reset", b32(OpcodeValid & ~MemReqValid), 32'd1);
    reset_dut();
    accs.delete();
    repeat (4) cyc(1'b0, 32'd0, 100, 100, 100);
    chk_q("t6_req_after_reset", accs, 0, RESET_PC);

    // random traffic with random redirects and one mid-stream reset
    for (int blk = 0; blk < 30; blk++) begin
      p_rdy  = $urandom_range(100);
      p_resp = $urandom_range(100);
      p_opr  = $urandom_range(100);
      if (blk == 15) reset_dut();
      for (int k = 0; k < 50; k++) begin
        rpc = $urandom();
        if ($urandom_range(3) == 0) rpc[31:4] = 28'hFFF_FFFF;
        cyc(($urandom_range(99) < 4), rpc, p_rdy, p_resp, p_opr);
      end
    end
    repeat (20) cyc(1'b0, 32'd0, 100, 100, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
